vmicro16_apb_arbiter: RTL

//  Round-robin arbiter sharing one APB master port (M_*) between NCORES core-side
//  APB masters (S_*). Sits between the vmicro16 cores and the APB interconnect that

---
 rtl/vmicro16_apb_arbiter_if.sv | 39 +++
 rtl/vmicro16_apb_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vmicro16_apb_arbiter_if.sv
// Bus bundle between the vmicro16 cores, the round-robin arbiter and the APB interconnect.
// S_* is the core-facing side; M_* is the single shared master port.
interface vmicro16_apb_arbiter_if #(
  parameter int NCORES = 2,
  parameter int AW     = 16,
  parameter int DW     = 16
);
  logic [NCORES*AW-1:0] S_PADDR;
  logic [NCORES-1:0]    S_PWRITE;
  logic [NCORES-1:0]    S_PSEL;
  logic [NCORES-1:0]    S_PENABLE;
  logic [NCORES*DW-1:0] S_PWDATA;
  logic [DW-1:0]        S_PRDATA;
  logic [NCORES-1:0]    S_PREADY;

  logic [AW-1:0]        M_PADDR;
  logic                 M_PWRITE;
  logic                 M_PSEL;
  logic                 M_PENABLE;
  logic [DW-1:0]        M_PWDATA;
  logic [DW-1:0]        M_PRDATA;
  logic                 M_PREADY;

  // Arbiter view: serves the cores, masters the shared bus.
  modport master (
    input  S_PADDR, S_PWRITE, S_PSEL, S_PENABLE, S_PWDATA,
    output S_PRDATA, S_PREADY,
    output M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA,
    input  M_PRDATA, M_PREADY
  );

  // Environment view: cores plus interconnect/slave.
  modport slave (
    output S_PADDR, S_PWRITE, S_PSEL, S_PENABLE, S_PWDATA,
    input  S_PRDATA, S_PREADY,
    input  M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA,
    output M_PRDATA, M_PREADY
  );
endinterface

// File: rtl/vmicro16_apb_arbiter.sv
// Round-robin arbiter granting the shared APB master port one whole transfer at a time.
// Optional ACCESS watchdog with sticky `timeout` flag: define APB_ARB_TIMEOUT_EN.
module vmicro16_apb_arbiter #(
  parameter int NCORES  = 2,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  vmicro16_apb_arbiter_if.master bus,
  output logic [NCORES-1:0]     grant,
`ifdef APB_ARB_TIMEOUT_EN
  output logic                  timeout,
`endif
  output logic                  busy
);
  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]        r_state;
  logic [PW-1:0]     r_ptr;
  logic [NCORES-1:0] r_grant;
  logic              r_busy;
  logic [AW-1:0]     r_paddr;
  logic              r_pwrite;
  logic              r_psel;
  logic              r_penable;
  logic [DW-1:0]     r_pwdata;

  logic              w_found;
  logic              w_hit;
  logic [PW-1:0]     w_idx;
  logic [PW-1:0]     w_pick;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_wdata;
  logic              w_to;
  logic              w_done;
  logic              w_access;

  // First requester strictly after the last owner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_idx   = '0;
    w_pick  = '0;
    for (int k = 1; k <= NCORES; k++) begin
      w_idx   = PW'((int'(r_ptr) + k) % NCORES);
      w_hit   = !w_found && bus.S_PSEL[w_idx];
      w_pick  = w_hit ? w_idx : w_pick;
      w_found = w_found | w_hit;
    end
  end

  assign w_addr   = bus.S_PADDR[w_pick*AW +: AW];
  assign w_wdata  = bus.S_PWDATA[w_pick*DW +: DW];
  assign w_access = (r_state == ST_ACCESS);

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] r_wait;
  logic       r_timeout;

  // Wait counter: zeroed in SETUP so ACCESS cycle n sees n-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ST_ACCESS) begin
        r_wait <= r_wait + 8'd1;
      end else begin
        r_wait <= 8'd0;
      end
      if (w_access && w_to) begin
        r_timeout <= 1'b1;
      end else begin
        r_timeout <= r_timeout;
      end
    end
  end

  assign w_to         = (r_wait == 8'(TIMEOUT - 1)) && !bus.M_PREADY;
  assign timeout      = r_timeout;
  assign bus.S_PRDATA = (w_access && w_to) ? DW'(16'hDEAD) : bus.M_PRDATA;
`else
  assign w_to         = 1'b0;
  assign bus.S_PRDATA = bus.M_PRDATA;
`endif

  assign w_done = bus.M_PREADY | w_to;

  // Main transfer FSM; every bus-facing field is captured once at grant time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= PW'(NCORES - 1);
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state   <= ST_SETUP;
            r_ptr     <= w_pick;
            r_grant   <= {{(NCORES-1){1'b0}}, 1'b1} << w_pick;
            r_busy    <= 1'b1;
            r_paddr   <= w_addr;
            r_pwrite  <= bus.S_PWRITE[w_pick];
            r_pwdata  <= w_wdata;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (w_done) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end else begin
            r_state <= ST_ACCESS;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_grant   <= '0;
          r_busy    <= 1'b0;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.M_PADDR   = r_paddr;
  assign bus.M_PWRITE  = r_pwrite;
  assign bus.M_PSEL    = r_psel;
  assign bus.M_PENABLE = r_penable;
  assign bus.M_PWDATA  = r_pwdata;
  assign bus.S_PREADY  = (w_access && w_done) ? r_grant : {NCORES{1'b0}};
  assign grant         = r_grant;
  assign busy          = r_busy;
endmodule
